// File: rtl/fp_add_sub_pkg.sv
// Shared widths and operand records for the FP add/sub datapath.
// Every block between unpack and normalize uses the same field layout.
package fp_add_sub_pkg;

    localparam int EXP_W  = 11;
    localparam int SIG_W  = 53;
    localparam int MANT_W = SIG_W + 2;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp_unpacked_t;

    typedef struct packed {
        logic              swapped;
        logic              sign_l;
        logic              sign_s;
        logic [EXP_W-1:0]  exp_l;
        logic [MANT_W-1:0] mant_l;
        logic [MANT_W-1:0] mant_s;
        logic              sticky;
    } fp_aligned_t;

endpackage

// File: rtl/fp_mantissa_align_if.sv
// Operand-in / aligned-out stream of the mantissa alignment stage.
interface fp_mantissa_align_if;
    import fp_add_sub_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              sign_a;
    logic              sign_b;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [SIG_W-1:0]  sig_a;
    logic [SIG_W-1:0]  sig_b;
    logic              out_valid;
    logic              out_ready;
    logic              swapped;
    logic              sign_l;
    logic              sign_s;
    logic [EXP_W-1:0]  exp_l;
    logic [MANT_W-1:0] mant_l;
    logic [MANT_W-1:0] mant_s;
    logic              sticky;

    modport master (
        output in_valid, sign_a, sign_b, exp_a, exp_b, sig_a, sig_b, out_ready,
        input  in_ready, out_valid, swapped, sign_l, sign_s, exp_l, mant_l, mant_s, sticky
    );

    modport slave (
        input  in_valid, sign_a, sign_b, exp_a, exp_b, sig_a, sig_b, out_ready,
        output in_ready, out_valid, swapped, sign_l, sign_s, exp_l, mant_l, mant_s, sticky
    );

endinterface

// File: rtl/sticky_right_shift.sv
// Log-stage right barrel shifter that ORs every dropped bit into sticky.
// Shift amounts of MANT_W or more flush the whole word into sticky.
module sticky_right_shift
    import fp_add_sub_pkg::*;
(
    input  logic [MANT_W-1:0] ext,
    input  logic [EXP_W-1:0]  d,
    output logic [MANT_W-1:0] shifted,
    output logic              sticky
);
    localparam int SH_W = $clog2(MANT_W);

    logic [MANT_W-1:0] stage_v [0:SH_W];
    logic [SH_W:0]     stk;
    logic              sat;

    assign stage_v[0] = ext;
    assign stk[0]     = 1'b0;

    for (genvar k = 0; k < SH_W; k++) begin : g_stage
        localparam int AMT = 1 << k;
        localparam logic [MANT_W-1:0] MASK = (MANT_W'(1) << AMT) - MANT_W'(1);
        assign stage_v[k+1] = d[k] ? (stage_v[k] >> AMT) : stage_v[k];
        assign stk[k+1]     = stk[k] | (d[k] & (|(stage_v[k] & MASK)));
    end

    // Upper shift bits beyond SH_W are covered by the saturation compare.
    assign sat     = (d >= EXP_W'(MANT_W));
    assign shifted = sat ? '0 : stage_v[SH_W];
    assign sticky  = sat ? (|ext) : stk[SH_W];

endmodule

// File: rtl/fp_mantissa_align.sv
// Pre-add alignment: orders operands by magnitude (stage 1), then
// right-shifts the smaller significand with guard/round/sticky (stage 2).
module fp_mantissa_align
    import fp_add_sub_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    fp_mantissa_align_if.slave bus
);
    fp_unpacked_t      op_a;
    fp_unpacked_t      op_b;
    fp_unpacked_t      big_c;
    fp_unpacked_t      small_c;
    logic              swap_c;
    logic [EXP_W-1:0]  diff_c;

    logic              vld_p1;
    logic              vld_p2;
    logic              adv_p1;
    logic              swapped_p1;
    fp_unpacked_t      l_p1;
    logic              sign_s_p1;
    logic [SIG_W-1:0]  sig_s_p1;
    logic [EXP_W-1:0]  diff_p1;

    logic [MANT_W-1:0] sh_mant;
    logic              sh_sticky;
    fp_aligned_t       out_p2;

    assign op_a    = {bus.sign_a, bus.exp_a, bus.sig_a};
    assign op_b    = {bus.sign_b, bus.exp_b, bus.sig_b};
    assign swap_c  = ({op_b.exp, op_b.sig} > {op_a.exp, op_a.sig});
    assign big_c   = swap_c ? op_b : op_a;
    assign small_c = swap_c ? op_a : op_b;
    assign diff_c  = big_c.exp - small_c.exp;

    assign adv_p1       = ~vld_p2 | bus.out_ready;
    assign bus.in_ready = ~vld_p1 | adv_p1;

    // Stage 0 -> 1: magnitude ordering
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (bus.in_ready) begin
            vld_p1 <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) begin
            swapped_p1 <= swap_c;
            l_p1       <= big_c;
            sign_s_p1  <= small_c.sign;
            sig_s_p1   <= small_c.sig;
            diff_p1    <= diff_c;
        end
    end

    sticky_right_shift u_shift (
        .ext     ({sig_s_p1, 2'b00}),
        .d       (diff_p1),
        .shifted (sh_mant),
        .sticky  (sh_sticky)
    );

    // Stage 1 -> 2: alignment shift; output data cleared on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            out_p2 <= '0;
        end else if (adv_p1) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_p2 <= {swapped_p1, l_p1.sign, sign_s_p1, l_p1.exp,
                           {l_p1.sig, 2'b00}, sh_mant, sh_sticky};
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.swapped   = out_p2.swapped;
    assign bus.sign_l    = out_p2.sign_l;
    assign bus.sign_s    = out_p2.sign_s;
    assign bus.exp_l     = out_p2.exp_l;
    assign bus.mant_l    = out_p2.mant_l;
    assign bus.mant_s    = out_p2.mant_s;
    assign bus.sticky    = out_p2.sticky;

endmodule

// File: tb/tb_fp_mantissa_align.sv
// Bench for fp_mantissa_align: directed table, backpressure/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_fp_mantissa_align;
    import fp_add_sub_pkg::*;

    localparam logic [SIG_W-1:0]  S1 = 53'h10_0000_0000_0000;
    localparam logic [MANT_W-1:0] M1 = 55'h40_0000_0000_0000;

    typedef struct {
        fp_unpacked_t      a;
        fp_unpacked_t      b;
        logic              swapped;
        logic              sign_l;
        logic [EXP_W-1:0]  exp_l;
        logic [MANT_W-1:0] mant_l;
        logic [MANT_W-1:0] mant_s;
        logic              sticky;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   n_in = 0;
    fp_aligned_t sb[$];
    fp_aligned_t mon_exp;
    vec_t vecs[$];

    fp_mantissa_align_if bus ();

    fp_mantissa_align dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: ordering by {exp,sig}, shift with plain >>, sticky = bits lost.
    function automatic fp_aligned_t model(fp_unpacked_t a, fp_unpacked_t b);
        fp_aligned_t r;
        fp_unpacked_t l, s;
        int unsigned d;
        logic [MANT_W-1:0] ext;
        r.swapped = ({b.exp, b.sig} > {a.exp, a.sig});
        l = r.swapped ? b : a;
        s = r.swapped ? a : b;
        r.sign_l = l.sign;
        r.sign_s = s.sign;
        r.exp_l  = l.exp;
        r.mant_l = {l.sig, 2'b00};
        d   = int'(l.exp) - int'(s.exp);
        ext = {s.sig, 2'b00};
        if (d >= MANT_W) begin
            r.mant_s = '0;
            r.sticky = |s.sig;
        end else begin
            r.mant_s = ext >> d;
            r.sticky = ((r.mant_s << d) != ext);
        end
        return r;
    endfunction

    function automatic fp_aligned_t dut_out();
        return {bus.swapped, bus.sign_l, bus.sign_s, bus.exp_l,
                bus.mant_l, bus.mant_s, bus.sticky};
    endfunction

    function automatic logic [SIG_W-1:0] rsig();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom % 8)
            0:       return '0;
            1:       return r[SIG_W-1:0];
            default: return {1'b1, r[SIG_W-2:0]};
        endcase
    endfunction

    task automatic set_ops(fp_unpacked_t a, fp_unpacked_t b);
        bus.sign_a = a.sign; bus.exp_a = a.exp; bus.sig_a = a.sig;
        bus.sign_b = b.sign; bus.exp_b = b.exp; bus.sig_b = b.sig;
    endtask

    task automatic rand_ops();
        fp_unpacked_t a, b;
        logic [EXP_W-1:0] delta;
        a.sign = 1'($urandom); b.sign = 1'($urandom);
        a.exp  = EXP_W'($urandom_range(0, 2047));
        case ($urandom % 5)
            0:       delta = '0;
            1, 2:    delta = EXP_W'($urandom_range(1, 8));
            3:       delta = EXP_W'($urandom_range(9, 70));
            default: delta = EXP_W'($urandom);
        endcase
        b.exp = a.exp - delta;
        a.sig = rsig();
        b.sig = ($urandom % 6 == 0) ? a.sig : rsig();
        if ($urandom % 2 == 1) set_ops(b, a);
        else set_ops(a, b);
    endtask

    task automatic send(fp_unpacked_t a, fp_unpacked_t b);
        bit ok;
        ok = 1'b0;
        set_ops(a, b);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stayed 0 expected 1");
        end
    endtask

    function automatic vec_t mk(fp_unpacked_t a, fp_unpacked_t b, logic sw, logic sl,
                                logic [EXP_W-1:0] el, logic [MANT_W-1:0] ml,
                                logic [MANT_W-1:0] ms, logic st);
        vec_t v;
        v.a = a; v.b = b; v.swapped = sw; v.sign_l = sl; v.exp_l = el;
        v.mant_l = ml; v.mant_s = ms; v.sticky = st;
        return v;
    endfunction

    // Scoreboard: the negedge view equals what transfers at the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_spurious: got %h expected no output", dut_out());
                end else begin
                    mon_exp = sb.pop_front();
                    check("sb_out", 128'(dut_out()), 128'(mon_exp));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model({bus.sign_a, bus.exp_a, bus.sig_a},
                                   {bus.sign_b, bus.exp_b, bus.sig_b}));
                n_in++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fp_aligned_t snap;
        int target, cyc;

        vecs.push_back(mk({1'b0, 11'h400, S1}, {1'b0, 11'h3FE, S1}, 0, 0, 11'h400, M1, 55'h10_0000_0000_0000, 0));
        vecs.push_back(mk({1'b0, 11'h3FF, S1}, {1'b1, 11'h401, S1}, 1, 1, 11'h401, M1, 55'h10_0000_0000_0000, 0));
        vecs.push_back(mk({1'b1, 11'h403, S1}, {1'b0, 11'h400, S1 | 53'h1}, 0, 1, 11'h403, M1, 55'h08_0000_0000_0000, 1));
        vecs.push_back(mk({1'b0, 11'h43C, S1}, {1'b0, 11'h400, 53'h1F_FFFF_FFFF_FFFF}, 0, 0, 11'h43C, M1, '0, 1));
        vecs.push_back(mk({1'b0, 11'h43C, S1}, {1'b0, 11'h400, 53'h0}, 0, 0, 11'h43C, M1, '0, 0));
        vecs.push_back(mk({1'b0, 11'h3FF, S1}, {1'b1, 11'h3FF, 53'h18_0000_0000_0000}, 1, 1, 11'h3FF, 55'h60_0000_0000_0000, M1, 0));
        vecs.push_back(mk({1'b1, 11'h3FF, S1}, {1'b0, 11'h3FF, S1}, 0, 1, 11'h3FF, M1, M1, 0));
        vecs.push_back(mk({1'b0, 11'h401, S1}, {1'b0, 11'h400, S1 | 53'h1}, 0, 0, 11'h401, M1, 55'h20_0000_0000_0002, 0));
        vecs.push_back(mk({1'b0, 11'h7FF, S1}, {1'b0, 11'h000, 53'h1}, 0, 0, 11'h7FF, M1, '0, 1));
        vecs.push_back(mk({1'b0, 11'h437, S1}, {1'b0, 11'h400, S1}, 0, 0, 11'h437, M1, '0, 1));
        vecs.push_back(mk({1'b0, 11'h436, S1}, {1'b0, 11'h400, S1}, 0, 0, 11'h436, M1, 55'h1, 0));

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_ops('0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 0);
        check("rst_data", 128'(dut_out()), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 128'(bus.in_ready), 1);

        // Directed vectors, one at a time, two-cycle latency.
        bus.out_ready = 1'b1;
        foreach (vecs[i]) begin
            set_ops(vecs[i].a, vecs[i].b);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check($sformatf("v%0d_early", i), 128'(bus.out_valid), 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_valid", i), 128'(bus.out_valid), 1);
            check($sformatf("v%0d_swapped", i), 128'(bus.swapped), 128'(vecs[i].swapped));
            check($sformatf("v%0d_sign_l", i), 128'(bus.sign_l), 128'(vecs[i].sign_l));
            check($sformatf("v%0d_exp_l", i), 128'(bus.exp_l), 128'(vecs[i].exp_l));
            check($sformatf("v%0d_mant_l", i), 128'(bus.mant_l), 128'(vecs[i].mant_l));
            check($sformatf("v%0d_mant_s", i), 128'(bus.mant_s), 128'(vecs[i].mant_s));
            check($sformatf("v%0d_sticky", i), 128'(bus.sticky), 128'(vecs[i].sticky));
        end
        @(posedge clk); #1;

        // Backpressure: two accepted, then stall with a third pending.
        bus.out_ready = 1'b0;
        send({1'b0, 11'h400, S1}, {1'b1, 11'h3F0, S1 | 53'h3});
        send({1'b1, 11'h123, S1 | 53'h5}, {1'b0, 11'h124, S1});
        check("bp_in_ready_low", 128'(bus.in_ready), 0);
        set_ops({1'b0, 11'h200, S1}, {1'b0, 11'h1C0, 53'h1F_FFFF_FFFF_FFFF});
        bus.in_valid = 1'b1;
        @(negedge clk);
        snap = dut_out();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 128'(bus.out_valid), 1);
            check("bp_hold_ready", 128'(bus.in_ready), 0);
            check("bp_hold_data", 128'(dut_out()), 128'(snap));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_stream_valid", 128'(bus.out_valid), 1);
            if (c == 0) check("bp_release_ready", 128'(bus.in_ready), 1);
            @(posedge clk); #1;
            if (c == 0) set_ops({1'b1, 11'h005, 53'h0}, {1'b0, 11'h005, S1});
            else if (c == 1) bus.in_valid = 1'b0;
        end
        @(negedge clk);
        check("bp_drained", 128'(sb.size()), 0);

        // Reset with both stages full flushes everything.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send({1'b0, 11'h300, S1}, {1'b0, 11'h2FF, S1});
        send({1'b0, 11'h301, S1}, {1'b0, 11'h2FF, S1});
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("flush_out_valid", 128'(bus.out_valid), 0);
        check("flush_data", 128'(dut_out()), 0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("flush_no_output", 128'(bus.out_valid), 0);
        end

        // Randomized traffic with random backpressure.
        target = n_in + 2000;
        cyc = 0;
        while (n_in < target && cyc < 20000) begin
            @(posedge clk); #1;
            rand_ops();
            bus.in_valid  = ($urandom % 4) != 0;
            bus.out_ready = ($urandom % 4) != 0;
            cyc++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("rand_all_sent", 128'(n_in >= target), 1);
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
        #1;
        check("rand_drained", 128'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
